// File: rtl/calc_btn_op_encoder.sv
// Button-to-opcode encoder for the calculator front panel.
// Synchronises and debounces the four board buttons and encodes debounced l/r/d into an ALU opcode.
// A debounced centre-button event commits that opcode through a valid/ready handshake.
module calc_btn_op_encoder #(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned CNT_W             = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int unsigned COMMIT_ON_RELEASE = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       btnl,
    input  logic       btnr,
    input  logic       btnd,
    input  logic       btnc,
    input  logic       op_ready,
    input  logic       overrun_clr,
    output logic [3:0] op_preview,
    output logic [3:0] alu_op,
    output logic       op_valid,
    output logic       op_overrun
);

    localparam int unsigned NumBtn = 4;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order used throughout: [3]=l, [2]=r, [1]=d, [0]=c.
    logic [NumBtn-1:0] btn_raw;
    assign btn_raw = {btnl, btnr, btnd, btnc};

    logic [SYNC_STAGES-1:0][NumBtn-1:0] sync_q;
    logic [NumBtn-1:0]                  sync_out;
    logic [NumBtn-1:0]                  db;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Shift raw levels through the synchroniser chain; raw levels are ignored while in reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    for (genvar b = 0; b < NumBtn; b++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q;
        logic             db_q;

        // Flip the debounced level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else if (sync_out[b] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                db_q  <= sync_out[b];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign db[b] = db_q;
    end

    function automatic logic [3:0] encode(input logic [2:0] lrd);
        logic [3:0] op;
        case (lrd)
            3'b000:  op = 4'b0000;
            3'b001:  op = 4'b0001;
            3'b010:  op = 4'b0100;
            3'b011:  op = 4'b0101;
            3'b100:  op = 4'b0110;
            3'b101:  op = 4'b1010;
            3'b110:  op = 4'b1011;
            default: op = 4'b1100;
        endcase
        return op;
    endfunction

    logic       prev_c_q;
    logic       commit;
    logic       drop;
    logic [3:0] cur_op;

    assign cur_op = encode(db[3:1]);

    // Single-cycle commit pulse from the debounced centre button edge of the selected polarity.
    always_comb begin
        commit = 1'b0;
        if (COMMIT_ON_RELEASE != 0) begin
            commit = ~db[0] & prev_c_q;
        end else begin
            commit = db[0] & ~prev_c_q;
        end
    end

    // A commit that arrives while the previous opcode is still unaccepted is lost.
    assign drop = commit & op_valid & ~op_ready;

    // Preview, commit handshake and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_c_q   <= 1'b0;
            op_preview <= 4'b0000;
            alu_op     <= 4'b0000;
            op_valid   <= 1'b0;
            op_overrun <= 1'b0;
        end else begin
            prev_c_q   <= db[0];
            op_preview <= cur_op;

            if (commit && !drop) begin
                alu_op   <= cur_op;
                op_valid <= 1'b1;
            end else if (!commit && op_valid && op_ready) begin
                op_valid <= 1'b0;
            end

            if (drop) begin
                op_overrun <= 1'b1;
            end else if (overrun_clr) begin
                op_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_btn_op_encoder.sv
// Bench for calc_btn_op_encoder: press-commit and release-commit instances share all stimulus.
// A behavioural model predicts committed opcodes into per-instance queues; a monitor pops them.
module tb_calc_btn_op_encoder;

    localparam int unsigned SyncStages = 2;
    localparam int unsigned DbCycles   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn      = 1'b0;
    logic btnl        = 1'b0;
    logic btnr        = 1'b0;
    logic btnd        = 1'b0;
    logic btnc        = 1'b0;
    logic op_ready    = 1'b0;
    logic overrun_clr = 1'b0;

    logic [3:0] dut_prev [2];
    logic [3:0] dut_aop  [2];
    logic       dut_val  [2];
    logic       dut_ovr  [2];

    calc_btn_op_encoder #(
        .SYNC_STAGES      (SyncStages),
        .DEBOUNCE_CYCLES  (DbCycles),
        .COMMIT_ON_RELEASE(0)
    ) u_dut_press (
        .clk        (clk),
        .resetn     (resetn),
        .btnl       (btnl),
        .btnr       (btnr),
        .btnd       (btnd),
        .btnc       (btnc),
        .op_ready   (op_ready),
        .overrun_clr(overrun_clr),
        .op_preview (dut_prev[0]),
        .alu_op     (dut_aop[0]),
        .op_valid   (dut_val[0]),
        .op_overrun (dut_ovr[0])
    );

    calc_btn_op_encoder #(
        .SYNC_STAGES      (SyncStages),
        .DEBOUNCE_CYCLES  (DbCycles),
        .COMMIT_ON_RELEASE(1)
    ) u_dut_release (
        .clk        (clk),
        .resetn     (resetn),
        .btnl       (btnl),
        .btnr       (btnr),
        .btnd       (btnd),
        .btnc       (btnc),
        .op_ready   (op_ready),
        .overrun_clr(overrun_clr),
        .op_preview (dut_prev[1]),
        .alu_op     (dut_aop[1]),
        .op_valid   (dut_val[1]),
        .op_overrun (dut_ovr[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Opcode table indexed by {l,r,d}.
    logic [3:0] enc_tab [8] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101,
                                4'b0110, 4'b1010, 4'b1011, 4'b1100};

    // Reference model state; button vectors are {l,r,d,c}.
    logic [3:0] pipe [$];
    logic [3:0] m_deb;
    int         m_run [4];
    logic       m_prevc;
    logic [3:0] m_prev;
    logic [3:0] m_aop [2];
    logic       m_val [2];
    logic       m_ovr [2];
    logic [3:0] exp_q0 [$];
    logic [3:0] exp_q1 [$];

    // Reference model, evaluated at each rising edge from the values the DUTs sample.
    always @(posedge clk) begin
        logic [3:0] s;
        logic [3:0] e;
        logic       cm;
        logic       drp;
        if (!resetn) begin
            pipe.delete();
            for (int i = 0; i < SyncStages; i++) pipe.push_back(4'b0000);
            m_deb   = 4'b0000;
            m_prevc = 1'b0;
            m_prev  = 4'b0000;
            for (int b = 0; b < 4; b++) m_run[b] = 0;
            for (int m = 0; m < 2; m++) begin
                m_aop[m] = 4'b0000;
                m_val[m] = 1'b0;
                m_ovr[m] = 1'b0;
            end
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            e = enc_tab[m_deb[3:1]];
            for (int m = 0; m < 2; m++) begin
                cm  = (m == 0) ? (m_deb[0] && !m_prevc) : (!m_deb[0] && m_prevc);
                drp = cm && m_val[m] && !op_ready;
                if (drp) m_ovr[m] = 1'b1;
                else if (overrun_clr) m_ovr[m] = 1'b0;
                if (cm && !drp) begin
                    m_aop[m] = e;
                    m_val[m] = 1'b1;
                    if (m == 0) exp_q0.push_back(e);
                    else exp_q1.push_back(e);
                end else if (!cm && m_val[m] && op_ready) begin
                    m_val[m] = 1'b0;
                end
            end
            m_prev  = e;
            m_prevc = m_deb[0];
            s = pipe.pop_front();
            pipe.push_back({btnl, btnr, btnd, btnc});
            for (int b = 0; b < 4; b++) begin
                if (s[b] != m_deb[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DbCycles) begin
                        m_deb[b] = s[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
    end

    logic mon_last_val [2] = '{1'b0, 1'b0};

    // Monitor: per-cycle status compare, and pop the scoreboard whenever a new opcode is presented.
    always @(posedge clk) begin
        logic [3:0] want;
        logic       avail;
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("preview[%0d]", m), dut_prev[m], m_prev);
            check($sformatf("valid[%0d]", m), {3'b000, dut_val[m]}, {3'b000, m_val[m]});
            check($sformatf("overrun[%0d]", m), {3'b000, dut_ovr[m]}, {3'b000, m_ovr[m]});
            if (dut_val[m] === 1'b1 && (!mon_last_val[m] || op_ready)) begin
                avail = (m == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
                check($sformatf("op_expected[%0d]", m), {3'b000, avail}, 4'b0001);
                if (avail) begin
                    want = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check($sformatf("alu_op[%0d]", m), dut_aop[m], want);
                end
            end
            mon_last_val[m] = (dut_val[m] === 1'b1);
        end
    end

    initial begin
        logic [3:0] rb;
        int         hold;

        // Reset with every button held high.
        {btnl, btnr, btnd, btnc} = 4'hf;
        wait_n(3);
        check("rst_valid", {3'b000, dut_val[0]}, 4'b0000);
        check("rst_aop", dut_aop[0], 4'b0000);
        check("rst_preview", dut_prev[0], 4'b0000);
        check("rst_overrun", {3'b000, dut_ovr[0]}, 4'b0000);
        resetn = 1'b1;
        wait_n(6);
        check("rst_valid_early", {3'b000, dut_val[0]}, 4'b0000);
        wait_n(1);
        check("rst_valid_t6", {3'b000, dut_val[0]}, 4'b0001);
        check("rst_aop_t6", dut_aop[0], 4'b1100);
        check("rst_rel_no_commit", {3'b000, dut_val[1]}, 4'b0000);
        op_ready = 1'b1;
        {btnl, btnr, btnd, btnc} = 4'h0;
        wait_n(12);

        // Bounce on btnc shorter than the debounce interval.
        repeat (5) begin
            btnc = 1'b1;
            wait_n(3);
            btnc = 1'b0;
            wait_n(1);
            check("bounce_valid", {3'b000, dut_val[0]}, 4'b0000);
        end
        wait_n(10);
        check("bounce_valid_end", {3'b000, dut_val[0]}, 4'b0000);
        check("bounce_overrun", {3'b000, dut_ovr[0]}, 4'b0000);

        // Encode sweep with immediate accept.
        for (int k = 0; k < 8; k++) begin
            {btnl, btnr, btnd} = k[2:0];
            wait_n(8);
            check("sweep_preview", dut_prev[0], enc_tab[k]);
            btnc = 1'b1;
            wait_n(7);
            check("sweep_valid", {3'b000, dut_val[0]}, 4'b0001);
            check("sweep_aop", dut_aop[0], enc_tab[k]);
            wait_n(1);
            check("sweep_drop", {3'b000, dut_val[0]}, 4'b0000);
            btnc = 1'b0;
            wait_n(8);
        end

        // Overrun: second commit while the first is unaccepted.
        op_ready = 1'b0;
        {btnl, btnr, btnd} = 3'b010;
        wait_n(8);
        btnc = 1'b1;
        wait_n(8);
        btnc = 1'b0;
        wait_n(8);
        check("ovr_first_aop", dut_aop[0], 4'b0100);
        {btnl, btnr, btnd} = 3'b110;
        wait_n(8);
        btnc = 1'b1;
        wait_n(8);
        check("ovr_aop_held", dut_aop[0], 4'b0100);
        check("ovr_valid", {3'b000, dut_val[0]}, 4'b0001);
        check("ovr_set", {3'b000, dut_ovr[0]}, 4'b0001);
        overrun_clr = 1'b1;
        wait_n(1);
        overrun_clr = 1'b0;
        check("ovr_cleared", {3'b000, dut_ovr[0]}, 4'b0000);
        op_ready = 1'b1;
        btnc = 1'b0;
        wait_n(12);

        // Accept on the same edge as a new commit: no bubble, no overrun.
        op_ready = 1'b0;
        {btnl, btnr, btnd} = 3'b001;
        wait_n(8);
        btnc = 1'b1;
        wait_n(8);
        btnc = 1'b0;
        wait_n(8);
        check("simul_first", dut_aop[0], 4'b0001);
        {btnl, btnr, btnd} = 3'b100;
        wait_n(8);
        btnc = 1'b1;
        wait_n(6);
        op_ready = 1'b1;
        wait_n(1);
        op_ready = 1'b0;
        check("simul_valid", {3'b000, dut_val[0]}, 4'b0001);
        check("simul_aop", dut_aop[0], 4'b0110);
        check("simul_ovr", {3'b000, dut_ovr[0]}, 4'b0000);
        op_ready = 1'b1;
        btnc = 1'b0;
        wait_n(12);

        // Release-commit instance: press does nothing, release commits after the full latency.
        btnc = 1'b1;
        wait_n(10);
        check("rel_press_none", {3'b000, dut_val[1]}, 4'b0000);
        btnc = 1'b0;
        wait_n(6);
        check("rel_early", {3'b000, dut_val[1]}, 4'b0000);
        wait_n(1);
        check("rel_commit", {3'b000, dut_val[1]}, 4'b0001);
        wait_n(8);

        // Reset in the middle of a release debounce.
        op_ready = 1'b0;
        btnc = 1'b1;
        wait_n(10);
        btnc = 1'b0;
        wait_n(3);
        resetn = 1'b0;
        wait_n(1);
        resetn = 1'b1;
        check("midrst_valid0", {3'b000, dut_val[0]}, 4'b0000);
        repeat (12) begin
            wait_n(1);
            check("midrst_valid1", {3'b000, dut_val[1]}, 4'b0000);
        end

        // Randomised buttons, ready and clear, with one reset partway through.
        for (int it = 0; it < 150; it++) begin
            rb   = 4'($urandom);
            hold = $urandom_range(1, 10);
            {btnl, btnr, btnd, btnc} = rb;
            if (it == 75) resetn = 1'b0;
            for (int h = 0; h < hold; h++) begin
                op_ready    = ($urandom_range(0, 3) != 0);
                overrun_clr = ($urandom_range(0, 15) == 0);
                @(negedge clk);
                resetn = 1'b1;
            end
        end

        // Drain every pending opcode.
        {btnl, btnr, btnd, btnc} = 4'h0;
        overrun_clr = 1'b0;
        op_ready    = 1'b1;
        wait_n(20);
        check("drain_q0", {3'b000, exp_q0.size() == 0}, 4'b0001);
        check("drain_q1", {3'b000, exp_q1.size() == 0}, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_btn_op_encoder.md
# calc_btn_op_encoder

Registered, debounced successor to the calculator's combinational button-to-opcode encoder. Synchronises and debounces the four board buttons, continuously encodes the debounced left/right/down buttons into a 4-bit ALU opcode, and commits that opcode on a debounced centre-button event through a valid/ready handshake to the calculator datapath. Sits between the raw button pins and the ALU/accumulator control.

## Interface

- SYNC_STAGES, 2: synchroniser flops per button input, minimum 2.
- DEBOUNCE_CYCLES, 500000: consecutive cycles a synchronised input must differ from its debounced state before the state flips, minimum 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width.
- COMMIT_ON_RELEASE, 0: 0 commits on debounced btnc press (rising); 1 commits on release (falling).

- clk  in  1  system clock.
- resetn  in  1  synchronous reset, active-low.
- btnl, btnr, btnd  in  1 each  raw asynchronous operation-select buttons.
- btnc  in  1  raw asynchronous commit button.
- op_ready  in  1  consumer accepts alu_op this cycle.
- overrun_clr  in  1  clears op_overrun.
- op_preview  out  4  registered encode of the current debounced l/r/d.
- alu_op  out  4  committed opcode; stable while op_valid=1.
- op_valid  out  1  committed opcode pending.
- op_overrun  out  1  sticky: a commit was dropped.

## Operation

- Reset (resetn=0 at an edge): all synchroniser flops, debounced states, counters, previous-btnc flop, op_preview, alu_op, op_valid, op_overrun -> 0. Raw button levels during reset are ignored.
- Debounce, per button, independent: if sync output == debounced state, counter -> 0. Else counter increments; at the edge where counter == DEBOUNCE_CYCLES-1 and the input still differs, debounced state flips and counter -> 0.
- Encoding of debounced (l,r,d): 000->0000, 001->0001, 010->0100, 011->0101, 100->0110, 101->1010, 110->1011, 111->1100. op_preview registers this every cycle.
- Commit event: single-cycle detect of debounced btnc vs. its registered previous value (rising if COMMIT_ON_RELEASE=0, falling if 1).
- Handshake, evaluated each edge:
  - commit and (op_valid=0 or op_ready=1): alu_op <- encode(current debounced l,r,d); op_valid <- 1.
  - commit and op_valid=1 and op_ready=0: commit dropped; alu_op, op_valid unchanged; op_overrun <- 1.
  - no commit, op_valid=1, op_ready=1: op_valid <- 0; alu_op holds last value.
- op_ready while op_valid=0 has no effect.
- op_overrun: set wins over overrun_clr in the same cycle; otherwise overrun_clr=1 clears it.
- alu_op never changes while op_valid=1 and op_ready=0.

## Timing

- Raw input first sampled at edge t, held stable: debounced state flips at edge t+SYNC_STAGES+DEBOUNCE_CYCLES-1.
- op_preview updates at edge t+SYNC_STAGES+DEBOUNCE_CYCLES.
- btnc commit: op_valid=1 and alu_op valid after edge t+SYNC_STAGES+DEBOUNCE_CYCLES.
- Glitch or bounce shorter than DEBOUNCE_CYCLES cycles (after sync) produces no debounced change.
- l/r/d used in a commit are the debounced values in the commit-detect cycle; a l/r/d change landing the same edge as the commit is not included.
- Handshake completes in the op_valid&op_ready cycle; op_valid low the next cycle. Back-to-back accept plus new commit keeps op_valid high with zero bubble.
- Reset asserted mid-debounce or mid-handshake: everything returns to reset values at that edge; a still-held button requires a full debounce interval after resetn returns high, and a held btnc at reset release produces a commit (previous-btnc flop reset to 0) when COMMIT_ON_RELEASE=0.

## Test plan

Bench parameters SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Reset: resetn=0 for 3 edges with all buttons high -> all outputs 0; release, buttons held -> op_valid=1 exactly 6 edges after first sampling edge, alu_op=1100.
- Bounce: btnc pulses high 3 cycles, low 1, repeated 5 times, then low -> op_valid stays 0, op_overrun 0.
- Encode sweep: for each of the 8 l/r/d combinations, settle, commit, op_ready=1 -> alu_op matches table (e.g. l=1,r=0,d=1 -> 1010), op_valid drops the cycle after accept; op_preview matches.
- Overrun: l=0,r=1,d=0 commit (0100), op_ready=0, change to l=1,r=1,d=0 and commit again -> alu_op stays 0100, op_overrun=1; overrun_clr=1 with no new drop -> op_overrun=0.
- Simultaneous accept and commit: op_valid=1 with 0001, op_ready=1 on the commit-detect edge of 0110 -> op_valid stays 1, alu_op=0110, no overrun.
- Release mode (COMMIT_ON_RELEASE=1): btnc press -> no commit; release -> op_valid 6 edges after first low sample; reset mid-debounce -> counters cleared, no commit.
